mul_accumulator: RTL
====================

# mul_accumulator

Sign-magnitude accumulator sitting directly downstream of the 3-bit sign-magnitude multiplier in the ALU datapath. It accepts a stream of 5-bit sign-magnitude products (bit 4 sign, bits 3:0 magnitude) over a valid/ready handshake. It sums a fixed batch of TERMS products into a wider sign-magnitude accumulator with saturation. It then presents the batch result with zero, negative and overflow flags over a second valid/ready handshake.

## Interface
- ACC_W, 8: accumulator width; bit ACC_W-1 is sign, bits ACC_W-2:0 are magnitude (max 127 at default).
- TERMS, 4: products per batch (legal range 1..255).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- clear  input  1  synchronous batch abort; same effect as rst, lower priority than rst.
- in_valid  input  1  product is presented.
- in_ready  output  1  block can accept a product.
- product  input  5  multiplier result, sign-magnitude.
- out_valid  output  1  batch result is available.
- out_ready  input  1  consumer accepts the result.
- acc  output  ACC_W  accumulated sum, sign-magnitude.
- zeroFlag  output  1  acc magnitude == 0.
- negativeFlag  output  1  acc sign bit.
- overflowFlag  output  1  sticky: saturation occurred in this batch.
- count  output  8  products accepted in the current batch.

## Operation
- States: ACCUM, DONE.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Product is accepted when in_valid=1.
  - On acceptance, acc is replaced by acc + product (sign-magnitude add) and count increments.
  - When the accepted product is number TERMS, the state moves to DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - acc, flags and count hold.
  - When out_ready=1, the state returns to ACCUM; acc, count and overflowFlag are cleared.
- Sign-magnitude add, with magnitudes zero-extended to ACC_W-1 bits:
  - Same sign: add magnitudes. If the sum exceeds 2^(ACC_W-1)-1, saturate to that value and set overflowFlag.
  - Different signs: result = larger magnitude minus smaller, with the sign of the larger.
  - Equal magnitudes with different signs: result is +0.
- Negative zero:
  - Input 5'b10000 is treated as +0 and never changes the sign of acc.
  - acc never holds negative zero; negativeFlag=0 whenever the magnitude is 0.
- After saturation, later products keep adding/subtracting from the saturated value. overflowFlag stays set until the batch is consumed, or until clear or rst.
- zeroFlag and negativeFlag are combinational from the registered acc.
- Priority: rst > clear > handshake.
- clear or rst in any state:
  - acc=0, count=0, overflowFlag=0, state ACCUM.
  - A product presented in the same cycle is dropped.

## Timing
- Reset values:
  - acc=0, count=0, overflowFlag=0.
  - zeroFlag=1, negativeFlag=0.
  - in_ready=1, out_valid=0, state ACCUM.
- Accumulate latency: acc and count reflect an accepted product on the next rising edge.
- A full-rate stream needs exactly TERMS cycles of in_valid=1.
- out_valid rises on the edge that accepts product number TERMS, so it is visible the cycle after that acceptance.
- Output handshake completes on a cycle with out_valid=1 and out_ready=1. in_ready returns to 1 the following cycle.
- No bubble-free overlap: in_ready=0 in every DONE cycle, including the cycle where out_ready is sampled high.
- out_ready held high continuously gives one DONE cycle per batch, so a batch takes TERMS+1 cycles.
- in_valid may stay high in DONE. Data is not consumed, and the producer must hold product stable until accepted.
- count wraps are impossible: it tops out at TERMS.

## Test plan
- TERMS=4, four products 01001 (+9) back-to-back, out_ready=1:
  - Required: out_valid one cycle after the 4th acceptance, acc=8'h24, zeroFlag=0, negativeFlag=0, overflowFlag=0, count=4.
- TERMS=4, products 01001, 11001, 00100, 10100:
  - Required after each: +9, +0, +4, +0.
  - Final acc=8'h00, zeroFlag=1, negativeFlag=0.
- TERMS=4, products 11001, 10000, 00000, 00011:
  - Required: acc=8'h86 (−6), negativeFlag=1, zeroFlag=0.
  - Intermediate acc after the second product stays 8'h89.
- TERMS=16, sixteen products 01001:
  - Required: acc saturates to 8'h7F at the 15th product; overflowFlag=1 from that cycle through DONE.
  - After out_ready, acc=0 and overflowFlag=0.
- Backpressure, TERMS=4:
  - Stimulus: after batch completion, hold out_ready=0 for 5 cycles with in_valid=1 and product 00001.
  - Required: in_ready=0 and acc/count unchanged for all 5 cycles.
  - Then out_ready=1 for one cycle; in_ready=1 the next cycle and the next batch starts from 0.
- Abort mid-batch:
  - Stimulus: after 2 accepted 01001 products, pulse clear together with in_valid=1.
  - Required: acc=0, count=0, that product dropped.
  - Repeat with rst; the next full batch of four 00010 gives acc=8'h08.

Source files
------------

// File: rtl/mul_accumulator.sv
// -----------------------------------------------------------------------------
// mul_accumulator
//
// Sums a fixed batch of TERMS 5-bit sign-magnitude products (bit 4 sign,
// bits 3:0 magnitude) into an ACC_W-bit sign-magnitude accumulator with
// saturation. The finished batch is presented together with zero, negative
// and sticky overflow flags.
//
// Handshakes: a transfer happens on a rising edge where valid=1 and ready=1
// on the same side. The producer holds valid and data stable until that edge.
// ready never depends on valid.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset (highest priority)
//   clear        synchronous batch abort, same effect as rst, below rst
//   in_valid     product presented
//   in_ready     block can accept a product (ACCUM state)
//   product      5-bit sign-magnitude product
//   out_valid    batch result available (DONE state)
//   out_ready    consumer accepts the result
//   acc          accumulated sum, sign-magnitude
//   zeroFlag     acc magnitude is zero
//   negativeFlag acc sign bit
//   overflowFlag saturation occurred in this batch (sticky)
//   count        products accepted in the current batch
//   dbg_state    current FSM state (0 = ACCUM, 1 = DONE)
// -----------------------------------------------------------------------------
module mul_accumulator #(
  parameter int ACC_W = 8,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             zeroFlag,
  output logic             negativeFlag,
  output logic             overflowFlag,
  output logic [7:0]       count,
  output logic             dbg_state
);

  localparam int MAG_W = ACC_W - 1;
  localparam logic [MAG_W-1:0] MAX_MAG = {MAG_W{1'b1}};

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [7:0]        r_count;
  logic              r_ovf;

  logic              w_accept;
  logic              w_last;
  logic              w_release;

  logic [MAG_W-1:0]  w_a_mag;
  logic              w_a_neg;
  logic [MAG_W-1:0]  w_p_mag;
  logic              w_p_neg;
  logic [MAG_W:0]    w_sum;
  logic [MAG_W-1:0]  w_res_mag;
  logic              w_res_neg;
  logic              w_sat;

  // ---------------------------------------------------------------------------
  // Sign-magnitude adder
  // ---------------------------------------------------------------------------
  assign w_a_mag = r_acc[MAG_W-1:0];
  assign w_a_neg = r_acc[ACC_W-1];
  assign w_p_mag = MAG_W'(product[3:0]);
  // A negative-zero product is folded to +0 so it can never flip acc's sign.
  assign w_p_neg = product[4] & (|product[3:0]);
  assign w_sum   = {1'b0, w_a_mag} + {1'b0, w_p_mag};

  always_comb begin
    w_res_mag = '0;
    w_res_neg = 1'b0;
    w_sat     = 1'b0;
    if (w_a_neg == w_p_neg) begin
      // Carry out of the magnitude field means the sum exceeds MAX_MAG.
      if (w_sum[MAG_W]) begin
        w_res_mag = MAX_MAG;
        w_sat     = 1'b1;
      end else begin
        w_res_mag = w_sum[MAG_W-1:0];
      end
      w_res_neg = w_a_neg;
    end else if (w_a_mag >= w_p_mag) begin
      w_res_mag = w_a_mag - w_p_mag;
      w_res_neg = w_a_neg;
    end else begin
      w_res_mag = w_p_mag - w_a_mag;
      w_res_neg = w_p_neg;
    end
    // Cancellation to zero always yields +0.
    if (w_res_mag == '0) begin
      w_res_neg = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        w_last   = in_valid && (r_count == 8'(TERMS - 1));
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        w_release = out_ready;
        if (out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_release) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= {w_res_neg, w_res_mag};
      r_count <= r_count + 8'd1;
      r_ovf   <= r_ovf | w_sat;
    end
  end

  assign acc          = r_acc;
  assign count        = r_count;
  assign overflowFlag = r_ovf;
  assign zeroFlag     = (r_acc[MAG_W-1:0] == '0);
  assign negativeFlag = r_acc[ACC_W-1];
  assign dbg_state    = r_state;

endmodule
